mem_rw_sched: RTL and testbench
===============================

Name: mem_rw_sched

Overview:
- Arbiter and sequencer that shares the single rw_address/write_data bus of the five-bank memory system (x, w1, w2, w3, w4) between two requesters.
  - Loader port: writes, used for host/DMA fill of input and weights.
  - Compute port: reads, used by the MAC engine fetching operands.
- Generates one-hot per-bank read_rq/write_rq strobes, range-checks addresses per bank, and returns registered read data with a valid pulse.

Parameters:
- X_DEPTH, 128, entries in bank x (sel 0)
- WL_DEPTH, 131072, entries in banks w1..w3 (sel 1..3)
- W4_DEPTH, 1280, entries in bank w4 (sel 4)
- AW, 17, address width
- DW, 8, data width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- ld_req  in  1  loader write request, held until ld_gnt
- ld_sel  in  3  loader target bank 0..4
- ld_addr  in  AW  loader address
- ld_data  in  DW  loader write data
- ld_gnt  out  1  one-cycle pulse: loader access is on the bus this cycle
- ld_err  out  1  valid with ld_gnt: access rejected (bad sel/address)
- rd_req  in  1  compute read request, held until rd_gnt
- rd_sel  in  3  compute target bank 0..4
- rd_addr  in  AW  compute address
- rd_gnt  out  1  one-cycle pulse: read access is on the bus this cycle
- rd_err  out  1  valid with rd_gnt: access rejected
- rd_valid  out  1  one-cycle pulse: rd_data valid
- rd_data  out  DW  read data, registered
- read_rq  out  5  per-bank read strobe {w4,w3,w2,w1,x}
- write_rq  out  5  per-bank write strobe {w4,w3,w2,w1,x}
- rw_address  out  AW  shared bank address
- write_data  out  DW  shared write data
- mem_rdata  in  5*DW  bank read data {w4,w3,w2,w1,x}; combinational from bank, same cycle as read_rq

Behaviour:
- Reset (async, rst=0): all outputs 0, including gnt/err/valid, strobes, rw_address, write_data and rd_data; round-robin pointer set so the loader wins the first conflict.
- Arbitration in cycle N; bus cycle N+1 (all bus outputs registered):
  - Eligible requester: req=1 and its gnt is not high in cycle N. A requester is never re-granted on its own held req.
  - One eligible: grant it. Both eligible: grant the one not granted last; pointer updates on every grant.
  - Neither: N+1 strobes all 0; rw_address/write_data hold last values.
- Grant cycle N+1: matching gnt=1; payload captured from cycle N.
  - Valid loader grant: write_rq[ld_sel]=1, rw_address=ld_addr, write_data=ld_data; bank commits at end of N+1.
  - Valid compute grant: read_rq[rd_sel]=1, rw_address=rd_addr. rd_data <= mem_rdata[rd_sel] at end of N+1, so rd_valid=1 in N+2. Read latency is 2 cycles from first req sample to rd_valid.
- Range check: sel>4, or addr >= depth of selected bank, gives err=1 with gnt. No strobe is raised; rw_address and write_data are not updated. For a rejected read, rd_valid still pulses in N+2 with rd_data=0.
- Invariants:
  - At most one bit set across read_rq|write_rq in any cycle; read and write strobes are never both set.
  - Throughput: 1 access/cycle when both ports alternate; 1 per 2 cycles for a single port.
- Requester may drop req the cycle gnt is seen, or change payload and keep req high for the next access.
- Reset mid-operation: in-flight grant/read discarded; no rd_valid after reset release for pre-reset requests.

Optional Feature:
- MEM_SCHED_STATS_EN defined:
  - Adds outputs stat_wr (32 bits), stat_rd (32 bits) and stat_err (16 bits): saturating counts of accepted writes, accepted reads and rejected accesses.
  - Cleared by reset and by input stat_clr (1 bit, synchronous, priority over increment).
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset release, ld_req sel=0 addr=5 data=0xA5 -> next cycle ld_gnt=1, write_rq=5'b00001, rw_address=5, write_data=0xA5.
- Then rd_req sel=0 addr=5 -> rd_gnt=1 with read_rq=5'b00001; next cycle rd_valid=1, rd_data=0xA5.
- ld_req and rd_req held high together for 6 cycles -> grants alternate ld,rd,ld,rd; never two strobes in one cycle.
- ld_req sel=4 addr=1280 -> ld_gnt=1, ld_err=1, write_rq=0; rd_req sel=6 -> rd_err=1, rd_valid next cycle, rd_data=0.
- rd_req sel=2 addr=131071 after writing 0x3C there -> rd_data=0x3C, rd_err=0.
- rst asserted the cycle after rd_gnt -> rd_valid stays 0, all strobes 0 immediately, ld wins first post-reset conflict.

Source files
------------

// File: rtl/mem_rw_sched.sv
// mem_rw_sched: two-port (loader write / compute read) round-robin scheduler for the shared five-bank memory bus
// Optional feature macro: MEM_SCHED_STATS_EN adds stat_clr input and saturating stat_wr/stat_rd/stat_err counters.
module mem_rw_sched #(
  parameter int X_DEPTH  = 128,
  parameter int WL_DEPTH = 131072,
  parameter int W4_DEPTH = 1280,
  parameter int AW       = 17,
  parameter int DW       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_req,
  input  logic [2:0]      ld_sel,
  input  logic [AW-1:0]   ld_addr,
  input  logic [DW-1:0]   ld_data,
  output logic            ld_gnt,
  output logic            ld_err,
  input  logic            rd_req,
  input  logic [2:0]      rd_sel,
  input  logic [AW-1:0]   rd_addr,
  output logic            rd_gnt,
  output logic            rd_err,
  output logic            rd_valid,
  output logic [DW-1:0]   rd_data,
  output logic [4:0]      read_rq,
  output logic [4:0]      write_rq,
  output logic [AW-1:0]   rw_address,
  output logic [DW-1:0]   write_data,
  input  logic [5*DW-1:0] mem_rdata
`ifdef MEM_SCHED_STATS_EN
  ,
  input  logic            stat_clr,
  output logic [31:0]     stat_wr,
  output logic [31:0]     stat_rd,
  output logic [15:0]     stat_err
`endif
);

  // true when the bank select is invalid or the address lies beyond the selected bank
  function automatic logic f_bad(input logic [2:0] sel, input logic [AW-1:0] addr);
    logic [31:0] a;
    a = 32'(addr);
    return sel > 3'd4 ? 1'b1 :
           sel == 3'd0 ? a >= 32'(X_DEPTH) :
           sel == 3'd4 ? a >= 32'(W4_DEPTH) : a >= 32'(WL_DEPTH);
  endfunction

  logic            r_last_ld;
  logic            w_ld_elig, w_rd_elig, w_pick_ld, w_pick_rd;
  logic            w_ld_ok, w_rd_ok, w_ld_bad, w_rd_bad;
  logic [4:0]      w_ld_oh, w_rd_oh;
  logic [DW-1:0]   w_rd_bank;

  // arbitration: a port whose gnt is high this cycle sits out, ties go to the port not granted last
  always_comb begin
    w_ld_elig = ld_req & ~ld_gnt;
    w_rd_elig = rd_req & ~rd_gnt;
    w_pick_ld = w_ld_elig & (~w_rd_elig | ~r_last_ld);
    w_pick_rd = w_rd_elig & ~w_pick_ld;
    w_ld_bad  = f_bad(ld_sel, ld_addr);
    w_rd_bad  = f_bad(rd_sel, rd_addr);
    w_ld_ok   = w_pick_ld & ~w_ld_bad;
    w_rd_ok   = w_pick_rd & ~w_rd_bad;
    w_ld_oh   = 5'b1 << ld_sel;
    w_rd_oh   = 5'b1 << rd_sel;
  end

  // read data mux keyed by the live read strobe, so a rejected read returns zero
  always_comb begin
    w_rd_bank = '0;
    for (int i = 0; i < 5; i++)
      w_rd_bank = w_rd_bank | (read_rq[i] ? mem_rdata[i*DW +: DW] : '0);
  end

  // bus cycle registers: grants, strobes, shared address/data and read return
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_ld  <= 1'b0;
      ld_gnt     <= 1'b0;
      ld_err     <= 1'b0;
      rd_gnt     <= 1'b0;
      rd_err     <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      read_rq    <= '0;
      write_rq   <= '0;
      rw_address <= '0;
      write_data <= '0;
    end else begin
      ld_gnt   <= w_pick_ld;
      ld_err   <= w_pick_ld & w_ld_bad;
      rd_gnt   <= w_pick_rd;
      rd_err   <= w_pick_rd & w_rd_bad;
      write_rq <= w_ld_ok ? w_ld_oh : '0;
      read_rq  <= w_rd_ok ? w_rd_oh : '0;
      rd_valid <= rd_gnt;
      if (w_pick_ld | w_pick_rd) r_last_ld <= w_pick_ld;
      if (w_ld_ok | w_rd_ok) rw_address <= w_ld_ok ? ld_addr : rd_addr;
      if (w_ld_ok) write_data <= ld_data;
      if (rd_gnt) rd_data <= w_rd_bank;
    end
  end

`ifdef MEM_SCHED_STATS_EN
  // saturating access counters, sampled from the bus cycle outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_wr  <= '0;
      stat_rd  <= '0;
      stat_err <= '0;
    end else if (stat_clr) begin
      stat_wr  <= '0;
      stat_rd  <= '0;
      stat_err <= '0;
    end else begin
      if (|write_rq && ~&stat_wr) stat_wr <= stat_wr + 32'd1;
      if (|read_rq && ~&stat_rd) stat_rd <= stat_rd + 32'd1;
      if (((ld_gnt & ld_err) | (rd_gnt & rd_err)) && ~&stat_err) stat_err <= stat_err + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_rw_sched.sv
// tb_mem_rw_sched: directed and randomized checks of mem_rw_sched against a transaction-level model
module tb_mem_rw_sched;
  localparam int AW = 17;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            ld_req = 1'b0, rd_req = 1'b0;
  logic [2:0]      ld_sel = '0, rd_sel = '0;
  logic [AW-1:0]   ld_addr = '0, rd_addr = '0;
  logic [DW-1:0]   ld_data = '0;
  logic            ld_gnt, ld_err, rd_gnt, rd_err, rd_valid;
  logic [DW-1:0]   rd_data, write_data;
  logic [4:0]      read_rq, write_rq;
  logic [AW-1:0]   rw_address;
  logic [5*DW-1:0] mem_rdata = '0;
  int checks = 0;
  int failures = 0;
  logic [7:0] env_mem [int];
  logic [7:0] ref_mem [int];

  mem_rw_sched dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_gnt(ld_gnt), .ld_err(ld_err),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_addr(rd_addr),
    .rd_gnt(rd_gnt), .rd_err(rd_err), .rd_valid(rd_valid), .rd_data(rd_data),
    .read_rq(read_rq), .write_rq(write_rq), .rw_address(rw_address),
    .write_data(write_data), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic int key(input int s, input int a);
    return s * 262144 + a;
  endfunction

  function automatic logic [7:0] dflt(input int k);
    return 8'(k) ^ 8'h5A;
  endfunction

  function automatic bit bad(input logic [2:0] s, input logic [AW-1:0] a);
    int d;
    d = (s == 3'd0) ? 128 : (s == 3'd4) ? 1280 : 131072;
    return (s > 3'd4) || (int'(a) >= d);
  endfunction

  // bank models: commit writes on the strobe, present read data for the current address
  always @(negedge clk) begin
    int k;
    for (int b = 0; b < 5; b++)
      if (write_rq[b]) env_mem[key(b, int'(rw_address))] = write_data;
    for (int b = 0; b < 5; b++) begin
      k = key(b, int'(rw_address));
      mem_rdata[b*DW +: DW] = env_mem.exists(k) ? env_mem[k] : dflt(k);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; ld_req = 1'b0; rd_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({ld_gnt, ld_err, rd_gnt, rd_err, rd_valid} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {ld_gnt, ld_err, rd_gnt, rd_err, rd_valid}); end
    checks++; if ({read_rq, write_rq} !== 10'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=0", {read_rq, write_rq}); end
    checks++; if ({rw_address, write_data, rd_data} !== '0) begin failures++; $display("FAIL reset_bus got=%h/%h/%h exp=0", rw_address, write_data, rd_data); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_write_read();
    ld_req = 1; ld_sel = 0; ld_addr = 5; ld_data = 8'hA5;
    @(negedge clk);
    checks++; if (ld_gnt !== 1'b1 || ld_err !== 1'b0) begin failures++; $display("FAIL wr_gnt got=%b%b exp=10", ld_gnt, ld_err); end
    checks++; if (write_rq !== 5'b00001 || read_rq !== 5'b0) begin failures++; $display("FAIL wr_strobe got=%b/%b exp=00001/00000", write_rq, read_rq); end
    checks++; if (rw_address !== 17'd5 || write_data !== 8'hA5) begin failures++; $display("FAIL wr_bus got=%0d/%h exp=5/a5", rw_address, write_data); end
    ld_req = 0; rd_req = 1; rd_sel = 0; rd_addr = 5;
    @(negedge clk);
    checks++; if (rd_gnt !== 1'b1 || rd_err !== 1'b0 || rd_valid !== 1'b0) begin failures++; $display("FAIL rd_gnt got=%b%b%b exp=100", rd_gnt, rd_err, rd_valid); end
    checks++; if (read_rq !== 5'b00001 || write_rq !== 5'b0) begin failures++; $display("FAIL rd_strobe got=%b/%b exp=00001/00000", read_rq, write_rq); end
    rd_req = 0;
    @(negedge clk);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin failures++; $display("FAIL rd_data got=%b/%h exp=1/a5", rd_valid, rd_data); end
    @(negedge clk);
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rd_valid_pulse got=%b exp=0", rd_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ld_req = 1; ld_sel = 1; ld_addr = 10; ld_data = 8'h11;
    rd_req = 1; rd_sel = 1; rd_addr = 10;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (ld_gnt !== (k % 2 == 0) || rd_gnt !== (k % 2 == 1)) begin failures++; $display("FAIL alt_gnt[%0d] got=%b%b exp=%b%b", k, ld_gnt, rd_gnt, k % 2 == 0, k % 2 == 1); end
      checks++; if ($countones({read_rq, write_rq}) != 1) begin failures++; $display("FAIL alt_strobe[%0d] got=%b/%b exp=one bit", k, read_rq, write_rq); end
    end
    ld_req = 0; rd_req = 0;
    @(negedge clk);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h11) begin failures++; $display("FAIL alt_rdata got=%b/%h exp=1/11", rd_valid, rd_data); end
    @(negedge clk);
  endtask

  task automatic test_errors();
    do_reset();
    rd_req = 1; rd_sel = 0; rd_addr = 5;
    @(negedge clk);
    rd_req = 0;
    @(negedge clk);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin failures++; $display("FAIL err_pre_rd got=%b/%h exp=1/a5", rd_valid, rd_data); end
    ld_req = 1; ld_sel = 4; ld_addr = 1280; ld_data = 8'h77;
    @(negedge clk);
    checks++; if (ld_gnt !== 1'b1 || ld_err !== 1'b1) begin failures++; $display("FAIL ld_err got=%b%b exp=11", ld_gnt, ld_err); end
    checks++; if (write_rq !== 5'b0 || read_rq !== 5'b0) begin failures++; $display("FAIL ld_err_strobe got=%b/%b exp=0/0", write_rq, read_rq); end
    checks++; if (rw_address !== 17'd5 || write_data !== 8'h00) begin failures++; $display("FAIL ld_err_bus got=%0d/%h exp=5/00", rw_address, write_data); end
    ld_req = 0; rd_req = 1; rd_sel = 6; rd_addr = 3;
    @(negedge clk);
    checks++; if (rd_gnt !== 1'b1 || rd_err !== 1'b1 || read_rq !== 5'b0) begin failures++; $display("FAIL rd_err got=%b%b/%b exp=11/00000", rd_gnt, rd_err, read_rq); end
    rd_req = 0;
    @(negedge clk);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin failures++; $display("FAIL rd_err_data got=%b/%h exp=1/00", rd_valid, rd_data); end
  endtask

  task automatic test_wl_top();
    ld_req = 1; ld_sel = 2; ld_addr = 17'd131071; ld_data = 8'h3C;
    @(negedge clk);
    checks++; if (write_rq !== 5'b00100 || ld_err !== 1'b0) begin failures++; $display("FAIL top_wr got=%b/%b exp=00100/0", write_rq, ld_err); end
    ld_req = 0; rd_req = 1; rd_sel = 2; rd_addr = 17'd131071;
    @(negedge clk);
    checks++; if (read_rq !== 5'b00100 || rd_err !== 1'b0) begin failures++; $display("FAIL top_rd got=%b/%b exp=00100/0", read_rq, rd_err); end
    rd_req = 0;
    @(negedge clk);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin failures++; $display("FAIL top_rdata got=%b/%h exp=1/3c", rd_valid, rd_data); end
  endtask

  task automatic test_reset_mid();
    rd_req = 1; rd_sel = 0; rd_addr = 5;
    @(negedge clk);
    checks++; if (rd_gnt !== 1'b1) begin failures++; $display("FAIL mid_rd_gnt got=%b exp=1", rd_gnt); end
    rd_req = 0; ld_req = 1; ld_sel = 0; ld_addr = 7; ld_data = 8'h99;
    @(negedge clk);
    checks++; if (ld_gnt !== 1'b1 || write_rq !== 5'b00001) begin failures++; $display("FAIL mid_ld_gnt got=%b/%b exp=1/00001", ld_gnt, write_rq); end
    rst = 0; ld_req = 0;
    #1;
    checks++; if ({read_rq, write_rq, ld_gnt, rd_gnt, rd_valid} !== 13'b0) begin failures++; $display("FAIL mid_async got=%b exp=0", {read_rq, write_rq, ld_gnt, rd_gnt, rd_valid}); end
    repeat (2) @(negedge clk);
    rst = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL mid_no_valid[%0d] got=%b exp=0", k, rd_valid); end
    end
    ld_req = 1; ld_sel = 0; ld_addr = 6; ld_data = 8'h42;
    rd_req = 1; rd_sel = 0; rd_addr = 6;
    @(negedge clk);
    checks++; if (ld_gnt !== 1'b1 || rd_gnt !== 1'b0) begin failures++; $display("FAIL mid_first_conflict got=%b%b exp=10", ld_gnt, rd_gnt); end
    ld_req = 0;
    @(negedge clk);
    checks++; if (rd_gnt !== 1'b1) begin failures++; $display("FAIL mid_rd_after got=%b exp=1", rd_gnt); end
    rd_req = 0;
    @(negedge clk);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h42) begin failures++; $display("FAIL mid_rdata got=%b/%h exp=1/42", rd_valid, rd_data); end
  endtask

  function automatic logic [2:0] rsel();
    return ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
  endfunction

  function automatic logic [AW-1:0] raddr(input logic [2:0] s);
    if (s == 3'd0) return 17'($urandom_range(64, 140));
    if (s == 3'd4) return 17'($urandom_range(1270, 1290));
    return ($urandom_range(0, 1) == 0) ? 17'($urandom_range(100, 115)) : 17'($urandom_range(131000, 131060));
  endfunction

  task automatic test_random();
    logic e_lg, e_le, e_rg, e_re, e_rv, last_ld, el, er, gl, gr, n_rv;
    logic [4:0] e_wrq, e_rrq;
    logic [AW-1:0] e_rwa;
    logic [7:0] e_wd, e_rd, pend, n_rd;
    int k;
    e_lg = 0; e_le = 0; e_rg = 0; e_re = 0; e_rv = 0; last_ld = 0;
    e_wrq = 0; e_rrq = 0; e_rwa = 0; e_wd = 0; e_rd = 0; pend = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      checks++; if (ld_gnt !== e_lg || rd_gnt !== e_rg) begin failures++; $display("FAIL rnd_gnt[%0d] got=%b%b exp=%b%b", c, ld_gnt, rd_gnt, e_lg, e_rg); end
      checks++; if ((e_lg && ld_err !== e_le) || (e_rg && rd_err !== e_re)) begin failures++; $display("FAIL rnd_err[%0d] got=%b%b exp=%b%b", c, ld_err, rd_err, e_le, e_re); end
      checks++; if (write_rq !== e_wrq || read_rq !== e_rrq) begin failures++; $display("FAIL rnd_strobe[%0d] got=%b/%b exp=%b/%b", c, write_rq, read_rq, e_wrq, e_rrq); end
      checks++; if (rw_address !== e_rwa || write_data !== e_wd) begin failures++; $display("FAIL rnd_bus[%0d] got=%0d/%h exp=%0d/%h", c, rw_address, write_data, e_rwa, e_wd); end
      checks++; if (rd_valid !== e_rv || (e_rv && rd_data !== e_rd)) begin failures++; $display("FAIL rnd_rdata[%0d] got=%b/%h exp=%b/%h", c, rd_valid, rd_data, e_rv, e_rd); end
      checks++; if ($countones({read_rq, write_rq}) > 1) begin failures++; $display("FAIL rnd_onehot[%0d] got=%b/%b exp=at most one", c, read_rq, write_rq); end
      if (!(ld_req && !e_lg)) begin
        ld_req = 1'($urandom_range(0, 1)); ld_sel = rsel(); ld_addr = raddr(ld_sel); ld_data = 8'($urandom);
      end
      if (!(rd_req && !e_rg)) begin
        rd_req = 1'($urandom_range(0, 1)); rd_sel = rsel(); rd_addr = raddr(rd_sel);
      end
      el = ld_req && !e_lg;
      er = rd_req && !e_rg;
      gl = el && (!er || !last_ld);
      gr = er && !gl;
      n_rv = e_rg;
      n_rd = e_re ? 8'h00 : pend;
      e_lg = gl; e_le = gl && bad(ld_sel, ld_addr);
      e_rg = gr; e_re = gr && bad(rd_sel, rd_addr);
      e_wrq = 0; e_rrq = 0;
      if (gl && !e_le) begin
        e_wrq[ld_sel] = 1'b1; e_rwa = ld_addr; e_wd = ld_data;
        ref_mem[key(int'(ld_sel), int'(ld_addr))] = ld_data;
      end
      if (gr && !e_re) begin
        e_rrq[rd_sel] = 1'b1; e_rwa = rd_addr;
        k = key(int'(rd_sel), int'(rd_addr));
        pend = ref_mem.exists(k) ? ref_mem[k] : dflt(k);
      end
      if (gl || gr) last_ld = gl;
      e_rv = n_rv;
      if (n_rv) e_rd = n_rd;
    end
    ld_req = 0; rd_req = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_errors();
    test_wl_top();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
